dm_access_ctrl: RTL

//   Sequences MEM-stage loads/stores onto a single-port synchronous data memory with RD_LAT-cycle read latency.

---
 rtl/dm_access_ctrl_pkg.sv | 41 ++++
 rtl/dm_load_lane.sv | 27 ++
 rtl/dm_access_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/dm_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: request opcodes,
// FSM states and store lane helpers.
package dm_access_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_WORD     = 3'b000,
    OP_BYTEZERO = 3'b001,
    OP_BYTESIGN = 3'b010,
    OP_HALFZERO = 3'b011,
    OP_HALFSIGN = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic logic [3:0] store_be(input logic [2:0] op, input logic [1:0] lane);
    logic [3:0] be;
    case (op)
      OP_WORD:                  be = 4'b1111;
      OP_BYTEZERO, OP_BYTESIGN: be = 4'b0001 << lane;
      OP_HALFZERO, OP_HALFSIGN: be = lane[1] ? 4'b1100 : 4'b0011;
      default:                  be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] wdata);
    logic [31:0] d;
    case (op)
      OP_BYTEZERO, OP_BYTESIGN: d = {4{wdata[7:0]}};
      OP_HALFZERO, OP_HALFSIGN: d = {2{wdata[15:0]}};
      default:                  d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dm_load_lane.sv
// Selects the addressed byte/half lane of a memory word and sign- or
// zero-extends it according to the load opcode.
module dm_load_lane
  import dm_access_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  op,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(word >> {lane, 3'b000});
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (op)
      OP_BYTEZERO: data = {24'b0, byte_sel};
      OP_BYTESIGN: data = {{24{byte_sel[7]}}, byte_sel};
      OP_HALFZERO: data = {16'b0, half_sel};
      OP_HALFSIGN: data = {{16{half_sel[15]}}, half_sel};
      default:     data = word;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Sequences MEM-stage loads/stores onto a single-port synchronous data memory
// with RD_LAT-cycle read latency, stalling the pipeline until the response.
module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int DM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] ADDR_LIMIT = 33'(DM_WORDS) * 33'd4;
  localparam logic [1:0]  LAT        = 2'(RD_LAT);

  state_e      state, next_state;
  logic        req_err;
  logic        lat_we;
  logic [2:0]  lat_op;
  logic [1:0]  lat_lane;
  logic [1:0]  cnt;
  logic [31:0] load_data;

  dm_load_lane u_load_lane (
    .word (mem_rdata),
    .lane (lat_lane),
    .op   (lat_op),
    .data (load_data)
  );

  always_comb begin
    req_err = 1'b0;
    case (req_op)
      OP_WORD:                  req_err = (req_addr[1:0] != 2'b00);
      OP_BYTEZERO, OP_BYTESIGN: req_err = 1'b0;
      OP_HALFZERO, OP_HALFSIGN: req_err = req_addr[0];
      default:                  req_err = 1'b1;
    endcase
    if ({1'b0, req_addr} >= ADDR_LIMIT) req_err = 1'b1;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (req_valid) next_state = req_err ? ST_RESP : ST_ACCESS;
      ST_ACCESS: next_state = lat_we ? ST_RESP : ST_WAIT;
      ST_WAIT:   if (cnt == LAT) next_state = ST_RESP;
      ST_RESP:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Memory-side and response outputs are registered off next_state so each is
  // asserted exactly for the cycle spent in the matching state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      lat_we     <= 1'b0;
      lat_op     <= '0;
      lat_lane   <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_en     <= 1'b0;
      mem_we     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= next_state;
      resp_valid <= (next_state == ST_RESP);
      mem_en     <= (next_state == ST_ACCESS);
      mem_we     <= '0;
      cnt        <= (state == ST_WAIT) ? cnt + 2'd1 : 2'd1;
      resp_rdata <= (state == ST_WAIT && cnt == LAT) ? load_data : '0;
      if (state == ST_RESP) resp_err <= 1'b0;
      if (state == ST_IDLE && req_valid) begin
        lat_we   <= req_we;
        lat_op   <= req_op;
        lat_lane <= req_addr[1:0];
        resp_err <= req_err;
      end
      if (next_state == ST_ACCESS) begin
        mem_addr  <= req_addr[31:2];
        mem_we    <= req_we ? store_be(req_op, req_addr[1:0]) : 4'b0000;
        mem_wdata <= store_data(req_op, req_wdata);
      end
    end
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    stall     = (state != ST_RESP) && (req_valid || state != ST_IDLE);
  end

endmodule
